// File: rtl/udp_rx_mchan.sv
// Multi-channel UDP/IPv4 receiver on an 8-bit GMII receive path.
// Strips all headers, filters on MAC/IP/port window and streams the payload with a per-frame FCS verdict.
//
// state | meaning
// IDLE  | waiting for a fresh e_rxdv rising edge carrying 8'h55
// PRE   | counting preamble bytes, waiting for SFD
// HDR   | capturing and checking the 42 MAC/IP/UDP header bytes
// PAY   | forwarding payload bytes to the channel stream
// TAIL  | absorbing pad and FCS, verdict on e_rxdv fall
// DROP  | frame rejected, waiting for e_rxdv to fall
module udp_rx_mchan #(
    parameter logic [47:0] LOCAL_MAC   = 48'h000a3501fec0,
    parameter logic [31:0] LOCAL_IP    = 32'hc0a80002,
    parameter logic [15:0] BASE_PORT   = 16'd8000,
    parameter int          NUM_CH      = 4,
    parameter bit          ALLOW_BCAST = 1'b1,
    parameter int          CH_W        = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            e_rxdv,
    input  logic [7:0]      rxd,
    output logic            out_valid,
    output logic            out_sop,
    output logic            out_eop,
    output logic [7:0]      out_data,
    output logic [CH_W-1:0] out_ch,
    output logic [47:0]     src_mac,
    output logic [31:0]     src_ip,
    output logic [15:0]     src_port,
    output logic [15:0]     pay_len,
    output logic            frm_done,
    output logic [1:0]      frm_err,
    output logic [15:0]     cnt_good,
    output logic [15:0]     cnt_crc,
    output logic [15:0]     cnt_drop
);

    localparam logic [31:0] CRC_RESIDUE = 32'hdebb20e3;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PAY, S_TAIL, S_DROP} state_t;

    state_t state, next_state;

    logic            rxdv_d;
    logic [2:0]      pre_cnt;
    logic [5:0]      off;
    logic [39:0]     sh;
    logic [47:0]     cur;
    logic [16:0]     port_off;
    logic            hdr_ok;
    logic [31:0]     crc, crc_nxt;
    logic [47:0]     t_mac;
    logic [31:0]     t_ip;
    logic [15:0]     t_port, t_len;
    logic [CH_W-1:0] t_ch;
    logic [15:0]     pay_cnt;
    logic            pay_last;

    logic            ov_n, osop_n, oeop_n, done_n;
    logic [1:0]      err_n;
    logic            inc_good, inc_crc, inc_drop;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hedb88320) : (r >> 1);
        return r;
    endfunction

    // cur holds the header bytes ending with the one on rxd right now
    assign cur      = {sh, rxd};
    assign port_off = {1'b0, cur[15:0]} - {1'b0, BASE_PORT};
    assign crc_nxt  = crc_byte(crc, rxd);
    assign pay_last = (pay_cnt == pay_len - 16'd1);

    always_comb begin
        hdr_ok = 1'b1;
        case (off)
            6'd5:  hdr_ok = (cur == LOCAL_MAC) || (ALLOW_BCAST && (cur == 48'hffffffffffff));
            6'd13: hdr_ok = (cur[15:0] == 16'h0800);
            6'd14: hdr_ok = (rxd == 8'h45);
            6'd23: hdr_ok = (rxd == 8'h11);
            6'd33: hdr_ok = (cur[31:0] == LOCAL_IP);
            6'd37: hdr_ok = (port_off < 17'(NUM_CH));
            6'd39: hdr_ok = (cur[15:0] >= 16'd8);
            default: hdr_ok = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (e_rxdv && !rxdv_d && rxd == 8'h55) next_state = S_PRE;
            S_PRE: begin
                if (!e_rxdv)                               next_state = S_IDLE;
                else if (rxd == 8'h55 && pre_cnt == 3'd7)  next_state = S_DROP;
                else if (rxd == 8'hd5)                     next_state = S_HDR;
                else if (rxd != 8'h55)                     next_state = S_DROP;
            end
            S_HDR: begin
                if (!e_rxdv)           next_state = S_IDLE;
                else if (!hdr_ok)      next_state = S_DROP;
                else if (off == 6'd41) next_state = (t_len != 16'd8) ? S_PAY : S_TAIL;
            end
            S_PAY: begin
                if (!e_rxdv)       next_state = S_IDLE;
                else if (pay_last) next_state = S_TAIL;
            end
            S_TAIL: if (!e_rxdv) next_state = S_IDLE;
            S_DROP: if (!e_rxdv) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        ov_n     = 1'b0;
        osop_n   = 1'b0;
        oeop_n   = 1'b0;
        done_n   = 1'b0;
        err_n    = 2'd0;
        inc_good = 1'b0;
        inc_crc  = 1'b0;
        inc_drop = (next_state == S_DROP) && (state != S_DROP);
        case (state)
            S_HDR: if (!e_rxdv) inc_drop = 1'b1;
            S_PAY: begin
                if (e_rxdv) begin
                    ov_n   = 1'b1;
                    osop_n = (pay_cnt == 16'd0);
                    oeop_n = pay_last;
                end else begin
                    done_n = 1'b1;
                    err_n  = 2'd2;
                end
            end
            S_TAIL: begin
                if (!e_rxdv) begin
                    done_n   = 1'b1;
                    err_n    = (crc == CRC_RESIDUE) ? 2'd0 : 2'd1;
                    inc_good = (crc == CRC_RESIDUE);
                    inc_crc  = (crc != CRC_RESIDUE);
                end
            end
            default: ;
        endcase
    end

    // rxdv_d resets high so a frame already in flight at reset release is never entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxdv_d  <= 1'b1;
            pre_cnt <= 3'd0;
            off     <= 6'd0;
            sh      <= 40'd0;
            crc     <= 32'd0;
            t_mac   <= 48'd0;
            t_ip    <= 32'd0;
            t_port  <= 16'd0;
            t_len   <= 16'd0;
            t_ch    <= '0;
            pay_cnt <= 16'd0;
        end else begin
            rxdv_d <= e_rxdv;
            case (state)
                S_IDLE: pre_cnt <= 3'd1;
                S_PRE: begin
                    if (e_rxdv && rxd == 8'h55 && pre_cnt != 3'd7)
                        pre_cnt <= pre_cnt + 3'd1;
                    off <= 6'd0;
                    crc <= 32'hffffffff;
                end
                S_HDR: begin
                    pay_cnt <= 16'd0;
                    if (e_rxdv) begin
                        sh  <= cur[39:0];
                        off <= off + 6'd1;
                        crc <= crc_nxt;
                        case (off)
                            6'd11: t_mac  <= cur;
                            6'd29: t_ip   <= cur[31:0];
                            6'd35: t_port <= cur[15:0];
                            6'd37: t_ch   <= port_off[CH_W-1:0];
                            6'd39: t_len  <= cur[15:0];
                            default: ;
                        endcase
                    end
                end
                S_PAY: begin
                    if (e_rxdv) begin
                        pay_cnt <= pay_cnt + 16'd1;
                        crc     <= crc_nxt;
                    end
                end
                S_TAIL: if (e_rxdv) crc <= crc_nxt;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= 8'd0;
            out_ch    <= '0;
            src_mac   <= 48'd0;
            src_ip    <= 32'd0;
            src_port  <= 16'd0;
            pay_len   <= 16'd0;
            frm_done  <= 1'b0;
            frm_err   <= 2'd0;
            cnt_good  <= 16'd0;
            cnt_crc   <= 16'd0;
            cnt_drop  <= 16'd0;
        end else begin
            out_valid <= ov_n;
            out_sop   <= osop_n;
            out_eop   <= oeop_n;
            frm_done  <= done_n;
            frm_err   <= err_n;
            if (ov_n)
                out_data <= rxd;
            if (state == S_HDR && e_rxdv && off == 6'd41) begin
                src_mac  <= t_mac;
                src_ip   <= t_ip;
                src_port <= t_port;
                pay_len  <= t_len - 16'd8;
                out_ch   <= t_ch;
            end
            if (inc_good) cnt_good <= cnt_good + 16'd1;
            if (inc_crc)  cnt_crc  <= cnt_crc + 16'd1;
            if (inc_drop) cnt_drop <= cnt_drop + 16'd1;
        end
    end

endmodule

// File: tb/tb_udp_rx_mchan.sv
// Directed bench for udp_rx_mchan: frames built byte by byte with an FCS computed here,
// payload stream and status checked against hand-derived expectations.
module tb_udp_rx_mchan;

    localparam logic [47:0] LOCAL_MAC = 48'h000a3501fec0;
    localparam logic [47:0] SRC_MAC   = 48'h021122334455;
    localparam logic [31:0] SRC_IP    = 32'hc0a8000a;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        e_rxdv = 1'b0;
    logic [7:0]  rxd = 8'h00;

    logic        out_valid, out_sop, out_eop, frm_done;
    logic [7:0]  out_data;
    logic [3:0]  out_ch;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [15:0] src_port, pay_len, cnt_good, cnt_crc, cnt_drop;
    logic [1:0]  frm_err;

    logic        nb_valid, nb_sop, nb_eop, nb_done;
    logic [7:0]  nb_data;
    logic [3:0]  nb_ch;
    logic [47:0] nb_src_mac;
    logic [31:0] nb_src_ip;
    logic [15:0] nb_src_port, nb_pay_len, nb_good, nb_crc, nb_drop;
    logic [1:0]  nb_err;

    int checks = 0;
    int failures = 0;

    logic [7:0] frm[$];
    logic [7:0] mon_data[$];
    bit         mon_sop[$];
    bit         mon_eop[$];
    int         done_cnt = 0;
    logic [1:0] last_err = 2'd0;
    int         nb_beats = 0;

    udp_rx_mchan dut (
        .clk(clk), .rst_n(rst_n), .e_rxdv(e_rxdv), .rxd(rxd),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data),
        .out_ch(out_ch), .src_mac(src_mac), .src_ip(src_ip), .src_port(src_port),
        .pay_len(pay_len), .frm_done(frm_done), .frm_err(frm_err),
        .cnt_good(cnt_good), .cnt_crc(cnt_crc), .cnt_drop(cnt_drop)
    );

    udp_rx_mchan #(.ALLOW_BCAST(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .e_rxdv(e_rxdv), .rxd(rxd),
        .out_valid(nb_valid), .out_sop(nb_sop), .out_eop(nb_eop), .out_data(nb_data),
        .out_ch(nb_ch), .src_mac(nb_src_mac), .src_ip(nb_src_ip), .src_port(nb_src_port),
        .pay_len(nb_pay_len), .frm_done(nb_done), .frm_err(nb_err),
        .cnt_good(nb_good), .cnt_crc(nb_crc), .cnt_drop(nb_drop)
    );

    initial forever #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) begin
            mon_data.push_back(out_data);
            mon_sop.push_back(out_sop);
            mon_eop.push_back(out_eop);
        end
        if (frm_done) begin
            done_cnt++;
            last_err = frm_err;
        end
        if (nb_valid) nb_beats++;
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hedb88320) : (r >> 1);
        return r;
    endfunction

    task automatic push16(input logic [15:0] v);
        frm.push_back(v[15:8]);
        frm.push_back(v[7:0]);
    endtask

    task automatic build(input logic [47:0] dmac, input logic [7:0] ver, input logic [7:0] proto,
                         input logic [15:0] dport, input logic [15:0] ulen, input int npay,
                         input bit fill55);
        logic [31:0] c;
        frm.delete();
        for (int i = 5; i >= 0; i--) frm.push_back(dmac[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(SRC_MAC[i*8 +: 8]);
        push16(16'h0800);
        frm.push_back(ver);
        frm.push_back(8'h00);
        push16(ulen + 16'd20);
        push16(16'h0000);
        push16(16'h0000);
        frm.push_back(8'h40);
        frm.push_back(proto);
        push16(16'h0000);
        push16(SRC_IP[31:16]);
        push16(SRC_IP[15:0]);
        push16(16'hc0a8);
        push16(16'h0002);
        push16(16'd1234);
        push16(dport);
        push16(ulen);
        push16(16'h0000);
        for (int i = 0; i < npay; i++) frm.push_back(fill55 ? 8'h55 : 8'(i));
        while (frm.size() < 60) frm.push_back(8'h00);
        c = 32'hffffffff;
        foreach (frm[i]) c = crc_upd(c, frm[i]);
        c = ~c;
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24]);
    endtask

    task automatic drive(input logic [7:0] b);
        @(posedge clk);
        #1;
        e_rxdv = 1'b1;
        rxd = b;
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        e_rxdv = 1'b0;
        rxd = 8'h00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int nsend);
        repeat (7) drive(8'h55);
        drive(8'hd5);
        for (int i = 0; i < nsend; i++) drive(frm[i]);
        idle(6);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, out_sop, out_eop, out_data, out_ch, frm_done, frm_err} !== 17'd0) begin
            failures++;
            $display("FAIL reset_stream: got %b want 0", {out_valid, out_sop, out_eop, out_data, out_ch, frm_done, frm_err});
        end
        checks++;
        if ({src_mac, src_ip, src_port, pay_len} !== 112'd0) begin
            failures++;
            $display("FAIL reset_info: got %h want 0", {src_mac, src_ip, src_port, pay_len});
        end
        checks++;
        if ({cnt_good, cnt_crc, cnt_drop} !== 48'd0) begin
            failures++;
            $display("FAIL reset_counters: got %h want 0", {cnt_good, cnt_crc, cnt_drop});
        end
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_good;
        int m, d0;
        m = mon_data.size();
        d0 = done_cnt;
        build(LOCAL_MAC, 8'h45, 8'h11, 16'd8002, 16'd26, 18, 1'b0);
        send(frm.size());
        checks++;
        if (mon_data.size() - m !== 18) begin
            failures++;
            $display("FAIL good_beats: got %0d want 18", mon_data.size() - m);
        end
        for (int i = 0; i < 18; i++) begin
            if (m + i < mon_data.size()) begin
                checks++;
                if ({mon_data[m+i], mon_sop[m+i], mon_eop[m+i]} !== {8'(i), i == 0, i == 17}) begin
                    failures++;
                    $display("FAIL good_beat%0d: got data=%h sop=%0d eop=%0d want data=%h sop=%0d eop=%0d",
                             i, mon_data[m+i], mon_sop[m+i], mon_eop[m+i], 8'(i), i == 0, i == 17);
                end
            end
        end
        checks++;
        if (done_cnt - d0 !== 1 || last_err !== 2'd0) begin
            failures++;
            $display("FAIL good_status: got done=%0d err=%0d want done=1 err=0", done_cnt - d0, last_err);
        end
        checks++;
        if (out_ch !== 4'd2 || pay_len !== 16'd18) begin
            failures++;
            $display("FAIL good_ch_len: got ch=%0d len=%0d want ch=2 len=18", out_ch, pay_len);
        end
        checks++;
        if (src_mac !== SRC_MAC || src_ip !== SRC_IP || src_port !== 16'd1234) begin
            failures++;
            $display("FAIL good_src: got %h %h %0d want %h %h 1234", src_mac, src_ip, src_port, SRC_MAC, SRC_IP);
        end
        checks++;
        if (cnt_good !== 16'd1 || cnt_crc !== 16'd0 || cnt_drop !== 16'd0) begin
            failures++;
            $display("FAIL good_counters: got good=%0d crc=%0d drop=%0d want 1 0 0", cnt_good, cnt_crc, cnt_drop);
        end
    endtask

    task automatic test_crc_err;
        int m, d0;
        bit ok;
        m = mon_data.size();
        d0 = done_cnt;
        build(LOCAL_MAC, 8'h45, 8'h11, 16'd8002, 16'd26, 18, 1'b0);
        frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
        send(frm.size());
        ok = (mon_data.size() - m == 18);
        for (int i = 0; i < 18 && ok; i++)
            ok = (mon_data[m+i] == 8'(i)) && (mon_sop[m+i] == (i == 0)) && (mon_eop[m+i] == (i == 17));
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL crc_stream: got %0d beats want 18 beats 00..11 with sop/eop", mon_data.size() - m);
        end
        checks++;
        if (done_cnt - d0 !== 1 || last_err !== 2'd1) begin
            failures++;
            $display("FAIL crc_status: got done=%0d err=%0d want done=1 err=1", done_cnt - d0, last_err);
        end
        checks++;
        if (cnt_crc !== 16'd1 || cnt_good !== 16'd1) begin
            failures++;
            $display("FAIL crc_counters: got crc=%0d good=%0d want 1 1", cnt_crc, cnt_good);
        end
    endtask

    task automatic test_filter;
        int m, d0;
        m = mon_data.size();
        d0 = done_cnt;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: build(48'h000a3501fec1, 8'h45, 8'h11, 16'd8001, 16'd26, 18, 1'b0);
                1: build(LOCAL_MAC, 8'h45, 8'h11, 16'd8004, 16'd26, 18, 1'b0);
                2: build(LOCAL_MAC, 8'h45, 8'h06, 16'd8001, 16'd26, 18, 1'b0);
                default: build(LOCAL_MAC, 8'h46, 8'h11, 16'd8001, 16'd26, 18, 1'b0);
            endcase
            send(frm.size());
            checks++;
            if (cnt_drop !== 16'(k + 1)) begin
                failures++;
                $display("FAIL filter_drop%0d: got %0d want %0d", k, cnt_drop, k + 1);
            end
        end
        checks++;
        if (mon_data.size() - m !== 0 || done_cnt - d0 !== 0) begin
            failures++;
            $display("FAIL filter_quiet: got beats=%0d done=%0d want 0 0", mon_data.size() - m, done_cnt - d0);
        end
        checks++;
        if (cnt_good !== 16'd1 || cnt_crc !== 16'd1) begin
            failures++;
            $display("FAIL filter_counters: got good=%0d crc=%0d want 1 1", cnt_good, cnt_crc);
        end
    endtask

    task automatic test_bcast;
        int m, d0, nb0;
        logic [15:0] nbd0;
        m = mon_data.size();
        d0 = done_cnt;
        nb0 = nb_beats;
        nbd0 = nb_drop;
        build(48'hffffffffffff, 8'h45, 8'h11, 16'd8000, 16'd26, 18, 1'b0);
        send(frm.size());
        checks++;
        if (mon_data.size() - m !== 18 || out_ch !== 4'd0) begin
            failures++;
            $display("FAIL bcast_accept: got beats=%0d ch=%0d want 18 0", mon_data.size() - m, out_ch);
        end
        checks++;
        if (done_cnt - d0 !== 1 || last_err !== 2'd0 || cnt_good !== 16'd2) begin
            failures++;
            $display("FAIL bcast_status: got done=%0d err=%0d good=%0d want 1 0 2", done_cnt - d0, last_err, cnt_good);
        end
        checks++;
        if (nb_beats - nb0 !== 0 || nb_drop - nbd0 !== 16'd1) begin
            failures++;
            $display("FAIL nobcast_drop: got beats=%0d drop_inc=%0d want 0 1", nb_beats - nb0, nb_drop - nbd0);
        end
    endtask

    task automatic test_zero_pay;
        int m, d0;
        m = mon_data.size();
        d0 = done_cnt;
        build(LOCAL_MAC, 8'h45, 8'h11, 16'd8001, 16'd8, 0, 1'b0);
        send(frm.size());
        checks++;
        if (mon_data.size() - m !== 0) begin
            failures++;
            $display("FAIL zero_beats: got %0d want 0", mon_data.size() - m);
        end
        checks++;
        if (done_cnt - d0 !== 1 || last_err !== 2'd0 || cnt_good !== 16'd3) begin
            failures++;
            $display("FAIL zero_status: got done=%0d err=%0d good=%0d want 1 0 3", done_cnt - d0, last_err, cnt_good);
        end
        checks++;
        if (pay_len !== 16'd0 || out_ch !== 4'd1) begin
            failures++;
            $display("FAIL zero_info: got len=%0d ch=%0d want 0 1", pay_len, out_ch);
        end
    endtask

    task automatic test_trunc;
        int m, d0;
        bit ok;
        m = mon_data.size();
        d0 = done_cnt;
        build(LOCAL_MAC, 8'h45, 8'h11, 16'd8003, 16'd28, 20, 1'b0);
        send(42 + 5);
        ok = (mon_data.size() - m == 5);
        for (int i = 0; i < 5 && ok; i++)
            ok = (mon_data[m+i] == 8'(i)) && (mon_sop[m+i] == (i == 0)) && !mon_eop[m+i];
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL trunc_stream: got %0d beats want 5 beats 00..04 sop first no eop", mon_data.size() - m);
        end
        checks++;
        if (done_cnt - d0 !== 1 || last_err !== 2'd2) begin
            failures++;
            $display("FAIL trunc_status: got done=%0d err=%0d want 1 2", done_cnt - d0, last_err);
        end
        checks++;
        if (cnt_good !== 16'd3 || cnt_crc !== 16'd1 || cnt_drop !== 16'd4) begin
            failures++;
            $display("FAIL trunc_counters: got good=%0d crc=%0d drop=%0d want 3 1 4", cnt_good, cnt_crc, cnt_drop);
        end
    endtask

    task automatic test_reset_mid;
        int m, d0;
        bit ok;
        build(LOCAL_MAC, 8'h45, 8'h11, 16'd8002, 16'd28, 20, 1'b1);
        repeat (7) drive(8'h55);
        drive(8'hd5);
        for (int i = 0; i < 48; i++) drive(frm[i]);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_sop, out_eop, out_data, frm_done, cnt_good, cnt_crc, cnt_drop, pay_len, src_ip} !== 108'd0) begin
            failures++;
            $display("FAIL midreset_clear: got valid=%0d good=%0d crc=%0d drop=%0d len=%0d want all 0",
                     out_valid, cnt_good, cnt_crc, cnt_drop, pay_len);
        end
        drive(frm[48]);
        drive(frm[49]);
        rst_n = 1'b1;
        m = mon_data.size();
        d0 = done_cnt;
        for (int i = 50; i < frm.size(); i++) drive(frm[i]);
        idle(6);
        checks++;
        if (mon_data.size() - m !== 0 || done_cnt - d0 !== 0 || cnt_drop !== 16'd0 || cnt_good !== 16'd0) begin
            failures++;
            $display("FAIL midreset_ignore: got beats=%0d done=%0d drop=%0d good=%0d want 0 0 0 0",
                     mon_data.size() - m, done_cnt - d0, cnt_drop, cnt_good);
        end
        m = mon_data.size();
        d0 = done_cnt;
        build(LOCAL_MAC, 8'h45, 8'h11, 16'd8002, 16'd26, 18, 1'b0);
        send(frm.size());
        ok = (mon_data.size() - m == 18);
        for (int i = 0; i < 18 && ok; i++)
            ok = (mon_data[m+i] == 8'(i)) && (mon_sop[m+i] == (i == 0)) && (mon_eop[m+i] == (i == 17));
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL midreset_next_stream: got %0d beats want 18 beats 00..11", mon_data.size() - m);
        end
        checks++;
        if (done_cnt - d0 !== 1 || last_err !== 2'd0 || cnt_good !== 16'd1 || out_ch !== 4'd2) begin
            failures++;
            $display("FAIL midreset_next_status: got done=%0d err=%0d good=%0d ch=%0d want 1 0 1 2",
                     done_cnt - d0, last_err, cnt_good, out_ch);
        end
    endtask

    initial begin
        test_reset;
        test_good;
        test_crc_err;
        test_filter;
        test_bcast;
        test_zero_pay;
        test_trunc;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/udp_rx_mchan.md
Name: udp_rx_mchan

Overview:
- Parametrised multi-channel UDP/IPv4 receiver on the 8-bit GMII-style receive path.
- Strips preamble, MAC, IPv4 and UDP headers. Filters on MAC, IP and a contiguous window of NUM_CH UDP ports.
- Streams the payload with sop/eop and a channel index, then issues a per-frame status pulse carrying the CRC-32 (FCS) verdict.
- Sits between the PHY receive interface and per-channel user FIFOs. Keeps wrapping statistics counters.

Parameters:
- LOCAL_MAC, 48'h000a3501fec0, accepted destination MAC.
- LOCAL_IP, 32'hc0a80002, accepted destination IPv4 address (192.168.0.2).
- BASE_PORT, 16'd8000, first accepted UDP destination port.
- NUM_CH, 4, number of consecutive accepted ports (1..16); channel k = port BASE_PORT+k.
- ALLOW_BCAST, 1, also accept destination MAC ff:ff:ff:ff:ff:ff when 1.
- CH_W, 4, width of the channel index; must satisfy 2**CH_W >= NUM_CH.

Ports:
- clk  in  1  receive clock
- rst_n  in  1  asynchronous active-low reset
- e_rxdv  in  1  receive data valid from PHY
- rxd  in  8  receive byte from PHY
- out_valid  out  1  payload byte valid
- out_sop  out  1  first payload byte of frame
- out_eop  out  1  last payload byte of frame (per UDP length)
- out_data  out  8  payload byte
- out_ch  out  CH_W  channel of current frame (dst port - BASE_PORT)
- src_mac  out  48  source MAC of last accepted frame
- src_ip  out  32  source IP of last accepted frame
- src_port  out  16  source UDP port of last accepted frame
- pay_len  out  16  UDP length - 8 of last accepted frame
- frm_done  out  1  one-cycle status pulse per accepted frame
- frm_err  out  2  valid with frm_done: 0 ok, 1 FCS error, 2 truncated
- cnt_good  out  16  accepted frames with frm_err=0, wrapping
- cnt_crc  out  16  accepted frames with frm_err=1, wrapping
- cnt_drop  out  16  frames rejected by filter or aborted in header, wrapping

Behaviour:
- Reset: the clock is clk; reset rst_n is asynchronous, active-low. All outputs and counters reset to 0 and the FSM goes to IDLE. Asserting reset mid-frame discards the frame with no status and no count. After release, the FSM resynchronises on the next e_rxdv rising edge only; it never enters a frame already in progress.
- States: IDLE, PRE, HDR, PAY, TAIL, DROP.
- IDLE -> PRE on e_rxdv=1 with rxd=8'h55 seen after e_rxdv was low.
- PRE:
  - 8'h55 stays in PRE; at most 7 are accepted.
  - 8'hd5 after >=1 byte of 8'h55 -> HDR, with byte counter cleared and CRC initialised to 32'hffffffff.
  - Any other byte, or an eighth 8'h55 -> DROP.
- HDR: 42 bytes at offsets 0..41 (14 MAC, 20 IP, 8 UDP), each captured on e_rxdv. Checks, any failure -> DROP:
  - offsets 0-5: dst MAC equals LOCAL_MAC, or equals broadcast with ALLOW_BCAST=1.
  - offsets 12-13: ethertype 16'h0800.
  - offset 14: 8'h45 exactly; IP options are unsupported.
  - offset 23: protocol 8'h11.
  - offsets 30-33: dst IP equals LOCAL_IP.
  - offsets 36-37: dst port in [BASE_PORT, BASE_PORT+NUM_CH-1], unsigned compare.
  - offsets 38-39: UDP length >= 8.
- Each check is evaluated on the cycle its last byte arrives, so a mismatch causes DROP before the next byte.
- At offset 41, latch src_mac, src_ip, src_port, pay_len = udp_len - 8 (16-bit) and out_ch. Then go to PAY if pay_len>0, else to TAIL.
- PAY:
  - Each rxd byte with e_rxdv=1 is output as out_valid=1, out_data=rxd, registered one cycle after sampling.
  - out_sop marks the first payload byte; out_eop marks byte pay_len. A single-byte payload has out_sop and out_eop in the same cycle.
  - After the eop byte -> TAIL.
- TAIL: absorbs Ethernet pad and FCS until e_rxdv falls. Output is idle.
- CRC-32 (IEEE 802.3, reflected, poly 32'h04c11db7) runs over every byte from offset 0 through the FCS. It is updated only on e_rxdv=1 in HDR/PAY/TAIL.
- On e_rxdv falling in TAIL: next cycle frm_done=1, with frm_err=0 if the CRC register equals the residue 32'hdebb20e3, else 1. Increment cnt_good or cnt_crc accordingly.
- e_rxdv falling in PAY: frm_done=1 with frm_err=2 and no out_eop; no counter increments. e_rxdv low within PAY without ending the frame is not supported; low is treated as end-of-frame.
- e_rxdv falling in HDR: no frm_done; cnt_drop increments.
- DROP: cnt_drop increments once on entry. Stay in DROP until e_rxdv=0, then go to IDLE. No outputs.
- Status for frame N completes before frame N+1 can reach HDR, since at least one idle cycle plus the preamble separates them. out_* is never asserted for dropped frames.
- Counters wrap from 16'hffff to 0.

Test Plan:
- Good frame: 7x55, d5, to LOCAL_MAC, 192.168.0.2:8002, udp_len=26, 18 payload bytes 00..11, valid FCS -> 18 out_valid beats, out_ch=2, sop on 00, eop on 11; frm_done with frm_err=0; cnt_good=1.
- Same frame with one FCS bit flipped -> identical payload stream, frm_err=1, cnt_crc=1, cnt_good unchanged.
- Filter rejects, each sent separately: wrong dst MAC, then dst port 8000+NUM_CH, then protocol 8'h06, then 8'h46 at offset 14 -> no out_valid, no frm_done, cnt_drop=4.
- Broadcast MAC with ALLOW_BCAST=1 and port 8000 -> accepted, out_ch=0. Rebuild with ALLOW_BCAST=0 -> dropped.
- udp_len=8 (zero payload) with valid FCS -> no out_valid, frm_done with frm_err=0. Then e_rxdv dropped after 5 of 20 payload bytes -> 5 beats, no eop, frm_err=2.
- rst_n asserted mid-payload, released while e_rxdv is still high -> outputs 0 immediately; remainder of frame ignored; next clean frame received correctly.
